pool_stream: RTL and testbench
==============================

# pool_stream

Streaming, parametrised 2-D pooling engine for the CNN datapath. It sits between a convolution stage's output and the next layer's input. Instead of taking a whole flattened feature map, it accepts one pixel per handshake in raster order, carrying all D channels of that pixel in parallel. It emits one pooled pixel for every K×K window. K is configurable and the stride equals K. Max or average pooling is selectable per frame, and partial results are buffered in a row buffer of W/K entries.

## Interface
- DATA_WIDTH, 16: signed two's-complement width of each channel sample.
- D, 6: number of channels carried in parallel per pixel.
- H, 28: input rows per frame. Must be a multiple of K.
- W, 28: input columns per frame. Must be a multiple of K.
- K, 2: pool window size and stride. Must be a power of two, ≥2.
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- in_data  in  D*DATA_WIDTH  one pixel. Channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- avg_mode  in  1  0 = max pooling, 1 = average pooling. Sampled only on the first pixel of a frame.
- out_data  out  (D)*DATA_WIDTH  pooled pixel, using the same channel packing as in_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  marks the final pooled pixel of a frame. Qualified by out_valid.

## Operation
- Accept happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Counters col (0..W-1) and row (0..H-1) advance only on accept.
  - col wraps to 0 and row increments.
  - At row=H-1, col=W-1 both wrap to 0; the next frame starts with no idle cycle.
- The mode register is loaded from avg_mode on an accept at (0,0). It holds for the rest of the frame.
- Horizontal accumulator hacc[D] is updated on each accept:
  - col%K==0: load the sample.
  - otherwise: combine with the sample.
  - Max mode combines with a signed max. Avg mode combines with a signed sum of width DATA_WIDTH+2*log2(K).
- When col%K==K-1, the combined value v (hacc combined with the current sample) goes to row buffer entry rb[col/K]:
  - row%K==0: rb := v.
  - 0<row%K<K-1: rb := combine(rb, v).
  - row%K==K-1: the output register is loaded with combine(rb, v). The rb entry is not written.
- Average result is the sum arithmetically shifted right by 2*log2(K) (floor toward −∞). It is then truncated to DATA_WIDTH, which is exact.
- Max result is the signed maximum of the K×K samples. Ties are irrelevant because values are equal.
- out_last is set with the output load when row==H-1 and col==W-1.
- in_ready = !out_valid || out_ready. This holds on every cycle, not only window-closing cycles, so ordering stays simple.
- Output count per frame is (H/K)*(W/K). Each output pixel holds D channels.
- Reset (async):
  - col, row, mode, out_valid, out_last, and out_data are cleared to 0.
  - hacc and rb are not cleared; they are always overwritten before use.
  - Reset mid-frame discards the partial frame. The next accept is treated as pixel (0,0).

## Timing
- Latency: out_valid rises on the clock edge that accepts the window's last pixel (bottom-right). Output is visible the cycle after acceptance, i.e. 1 cycle.
- Throughput: 1 pixel/cycle sustained while out_ready=1.
- Holding stable: out_data, out_valid, and out_last hold while out_valid && !out_ready.
  - in_ready is 0 during such a stall.
  - No accept occurs during the stall, so no output is lost.
- On the same cycle, an output transfer and an accept that closes a new window both occur. The output register reloads and out_valid stays 1.
- An output transfer with no new window close clears out_valid on that edge.
- in_valid=0 cycles freeze all state. Gaps anywhere in the frame are legal.
- avg_mode changes mid-frame are ignored until the next (0,0) accept.

## Test plan
- H=W=4, K=2, D=2, max mode. Ch0 = raster index 0..15, ch1 = negated index; in_valid is high continuously and out_ready=1. Expected outputs:
  - ch0 = 5, 7, 13, 15.
  - ch1 = −0, −2, −8, −10.
  - out_last is set only on the 4th output.
  - One output appears 1 cycle after inputs 5, 7, 13, 15 are accepted.
- Same stimulus in avg mode. Expected outputs:
  - ch0 = 2, 4, 10, 12.
  - ch1 = −3, −5, −11, −13 (floor of −2.5 gives −3).
- Backpressure: out_ready=0 for 5 cycles when the first output appears. Required behaviour:
  - in_ready=0 and out_data holds at 5 throughout the stall.
  - After release, all 4 outputs arrive in order with nothing lost or duplicated.
- Random in_valid gaps plus random out_ready over 3 back-to-back frames, alternating avg_mode per frame, checked against a reference model. A mid-frame avg_mode toggle must have no effect.
- Assert reset after 6 accepted pixels, then run a clean frame. Outputs must match the first test exactly, and out_valid must be 0 immediately after reset.
- K=4, H=W=8, D=1, all samples −32768 except one sample of +1 per window. Max output is 1 for each window. Avg output is floor((15*−32768+1)/16) = −30720.

Source files
------------

// File: rtl/pool_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pool_stream
// Brief    : Streaming KxK, stride-K max/average pooling over raster-order
//            pixels (D parallel channels) using a W/K-entry row buffer.
// Revision : 1.0
// ============================================================================
module pool_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 6,
    parameter int H          = 28,
    parameter int W          = 28,
    parameter int K          = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [D*DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  avg_mode,
    output logic [D*DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int LOG2K = $clog2(K);
    localparam int SH    = 2 * LOG2K;
    localparam int AW    = DATA_WIDTH + SH;
    localparam int CW    = $clog2(W);
    localparam int RW    = $clog2(H);
    localparam int NWIN  = W / K;
    localparam int RBW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    // Max mode keeps values sign-extended to AW so both modes share storage.
    function automatic logic signed [AW-1:0] f_comb(
        input logic signed [AW-1:0] a,
        input logic signed [AW-1:0] b,
        input logic                 avg
    );
        if (avg)
            return a + b;
        else
            return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]          r_col;
    logic [RW-1:0]          r_row;
    logic                   r_mode;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [D*DATA_WIDTH-1:0] r_out_data;

    logic                   w_in_ready;
    logic                   w_accept;
    logic [LOG2K-1:0]       w_cph;
    logic [LOG2K-1:0]       w_rph;
    logic                   w_col_first;
    logic                   w_col_ph_last;
    logic                   w_row_ph_first;
    logic                   w_row_ph_last;
    logic                   w_col_end;
    logic                   w_row_end;
    logic                   w_close;
    logic                   w_rb_store;
    logic [RBW-1:0]         w_rb_idx;
    logic [D*DATA_WIDTH-1:0] w_pooled;

    assign w_in_ready     = !r_out_valid || out_ready;
    assign w_accept       = in_valid && w_in_ready;
    assign w_cph          = r_col[LOG2K-1:0];
    assign w_rph          = r_row[LOG2K-1:0];
    assign w_col_first    = (w_cph == '0);
    assign w_col_ph_last  = (w_cph == LOG2K'(K-1));
    assign w_row_ph_first = (w_rph == '0);
    assign w_row_ph_last  = (w_rph == LOG2K'(K-1));
    assign w_col_end      = (r_col == CW'(W-1));
    assign w_row_end      = (r_row == RW'(H-1));
    assign w_close        = w_accept && w_col_ph_last && w_row_ph_last;
    assign w_rb_store     = w_col_ph_last && !w_row_ph_last;
    assign w_rb_idx       = RBW'(r_col >> LOG2K);

    for (genvar c = 0; c < D; c++) begin : g_ch
        logic signed [AW-1:0] r_hacc;
        logic signed [AW-1:0] r_rb [NWIN];
        logic signed [AW-1:0] w_samp;
        logic signed [AW-1:0] w_hv;
        logic signed [AW-1:0] w_rbv;
        logic signed [AW-1:0] w_win;

        assign w_samp = AW'($signed(in_data[c*DATA_WIDTH +: DATA_WIDTH]));
        assign w_hv   = w_col_first ? w_samp : f_comb(r_hacc, w_samp, r_mode);
        assign w_rbv  = r_rb[w_rb_idx];
        assign w_win  = f_comb(w_rbv, w_hv, r_mode);
        // Arithmetic shift floors toward -inf; the quotient always fits DATA_WIDTH.
        assign w_pooled[c*DATA_WIDTH +: DATA_WIDTH] =
            r_mode ? DATA_WIDTH'(w_win >>> SH) : DATA_WIDTH'(w_win);

        always_ff @(posedge clk) begin
            if (w_accept) begin
                r_hacc <= w_hv;
                if (w_rb_store)
                    r_rb[w_rb_idx] <= w_row_ph_first ? w_hv : w_win;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (r_col == '0 && r_row == '0)
                    r_mode <= avg_mode;
            end
            // A window close always wins; it can only happen when the old
            // output is being transferred or none is pending.
            if (w_close) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pooled;
                r_out_last  <= w_col_end && w_row_end;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_pool_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pool_stream
// Brief    : Directed bench for pool_stream (4x4/K2/D2 and 8x8/K4/D1 builds).
// Revision : 1.0
// ============================================================================
module tb_pool_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic [31:0] a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic        a_avg;
    logic [31:0] a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic        a_out_last;

    logic [15:0] b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic        b_avg;
    logic [15:0] b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_out_last;

    pool_stream #(.DATA_WIDTH(16), .D(2), .H(4), .W(4), .K(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .avg_mode(a_avg),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last)
    );

    pool_stream #(.DATA_WIDTH(16), .D(1), .H(8), .W(8), .K(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .avg_mode(b_avg),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last)
    );

    typedef struct {
        int c0;
        int c1;
        bit last;
    } exp_t;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t a_q[$];
    exp_t b_q[$];
    int   px0[16];
    int   px1[16];
    int   pxb[64];
    bit   rnd_ready = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void push_a(input int c0, input int c1, input bit last);
        exp_t e;
        e.c0 = c0; e.c1 = c1; e.last = last;
        a_q.push_back(e);
    endfunction

    function automatic void push_b(input int v, input bit last);
        exp_t e;
        e.c0 = v; e.c1 = 0; e.last = last;
        b_q.push_back(e);
    endfunction

    function automatic int pool4(input int p, input int q, input int r, input int s,
                                 input bit avg);
        int sum;
        int m;
        if (avg) begin
            sum = p + q + r + s;
            return (sum >= 0) ? sum / 4 : -((-sum + 3) / 4);
        end
        m = p;
        if (q > m) m = q;
        if (r > m) m = r;
        if (s > m) m = s;
        return m;
    endfunction

    function automatic void model_a(input bit avg);
        int base;
        for (int wr = 0; wr < 2; wr++)
            for (int wc = 0; wc < 2; wc++) begin
                base = wr * 8 + wc * 2;
                push_a(pool4(px0[base], px0[base+1], px0[base+4], px0[base+5], avg),
                       pool4(px1[base], px1[base+1], px1[base+4], px1[base+5], avg),
                       (wr == 1 && wc == 1));
            end
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!reset && a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
                chk("a_extra_output", 1, 0);
            end else begin
                e = a_q.pop_front();
                chk("a_ch0", int'($signed(a_out_data[15:0])), e.c0);
                chk("a_ch1", int'($signed(a_out_data[31:16])), e.c1);
                chk("a_last", int'(a_out_last), int'(e.last));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!reset && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                chk("b_extra_output", 1, 0);
            end else begin
                e = b_q.pop_front();
                chk("b_ch0", int'($signed(b_out_data)), e.c0);
                chk("b_last", int'(b_out_last), int'(e.last));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) a_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_a(input int c0, input int c1, input int gap);
        int n;
        a_in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        a_in_valid = 1'b1;
        a_in_data  = {16'(c1), 16'(c0)};
        n = 0;
        forever begin
            @(negedge clk);
            if (a_in_ready) begin @(posedge clk); #1; break; end
            @(posedge clk); #1;
            n++;
            if (n > 100) begin chk("a_accept_timeout", 0, 1); break; end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input int v);
        int n;
        b_in_valid = 1'b1;
        b_in_data  = 16'(v);
        n = 0;
        forever begin
            @(negedge clk);
            if (b_in_ready) begin @(posedge clk); #1; break; end
            @(posedge clk); #1;
            n++;
            if (n > 100) begin chk("b_accept_timeout", 0, 1); break; end
        end
        b_in_valid = 1'b0;
    endtask

    task automatic frame_a(input bit avg, input bit toggle, input bit lat, input int gapmax);
        a_avg = avg;
        for (int i = 0; i < 16; i++) begin
            if (toggle && i == 3) a_avg = ~avg;
            send_a(px0[i], px1[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
            if (lat) chk("a_latency", int'(a_out_valid), int'(i == 5 || i == 7 || i == 13 || i == 15));
        end
    endtask

    task automatic frame_b(input bit avg);
        int mk_r[4];
        int mk_c[4];
        mk_r = '{0, 1, 3, 2};
        mk_c = '{0, 2, 3, 1};
        for (int i = 0; i < 64; i++) pxb[i] = -32768;
        for (int w = 0; w < 4; w++) begin
            pxb[((w / 2) * 4 + mk_r[w]) * 8 + (w % 2) * 4 + mk_c[w]] = 1;
            push_b(avg ? -30720 : 1, (w == 3));
        end
        b_avg = avg;
        for (int i = 0; i < 64; i++) send_b(pxb[i]);
    endtask

    task automatic drain_a(input string tag);
        int n = 0;
        while (a_q.size() > 0 && n < 200) begin @(posedge clk); n++; end
        #1;
        chk(tag, a_q.size(), 0);
    endtask

    task automatic drain_b(input string tag);
        int n = 0;
        while (b_q.size() > 0 && n < 200) begin @(posedge clk); n++; end
        #1;
        chk(tag, b_q.size(), 0);
    endtask

    task automatic ramp_data();
        for (int i = 0; i < 16; i++) begin
            px0[i] = i;
            px1[i] = -i;
        end
    endtask

    task automatic push_max_ramp();
        push_a(5, 0, 1'b0);
        push_a(7, -2, 1'b0);
        push_a(13, -8, 1'b0);
        push_a(15, -10, 1'b1);
    endtask

    initial begin
        reset       = 1'b1;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_avg       = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_avg       = 1'b0;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(a_out_valid), 0);
        chk("reset_out_last", int'(a_out_last), 0);
        chk("reset_out_data", int'(a_out_data), 0);
        chk("reset_in_ready", int'(a_in_ready), 1);
        chk("reset_b_out_valid", int'(b_out_valid), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        ramp_data();
        push_max_ramp();
        frame_a(1'b0, 1'b0, 1'b1, 0);
        drain_a("max_drain");

        push_a(2, -3, 1'b0);
        push_a(4, -5, 1'b0);
        push_a(10, -11, 1'b0);
        push_a(12, -13, 1'b1);
        frame_a(1'b1, 1'b0, 1'b1, 0);
        drain_a("avg_drain");

        push_max_ramp();
        a_avg = 1'b0;
        for (int i = 0; i < 6; i++) send_a(px0[i], px1[i], 0);
        a_out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", int'(a_in_ready), 0);
            chk("stall_out_valid", int'(a_out_valid), 1);
            chk("stall_hold_ch0", int'($signed(a_out_data[15:0])), 5);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        for (int i = 6; i < 16; i++) send_a(px0[i], px1[i], 0);
        drain_a("stall_drain");

        rnd_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                px0[i] = int'($urandom_range(0, 65535)) - 32768;
                px1[i] = int'($urandom_range(0, 65535)) - 32768;
            end
            model_a(f[0]);
            frame_a(f[0], 1'b1, 1'b0, 2);
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        a_out_ready = 1'b1;
        drain_a("random_drain");

        ramp_data();
        a_avg = 1'b0;
        for (int i = 0; i < 6; i++) send_a(px0[i], px1[i], 0);
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", int'(a_out_valid), 0);
        chk("midreset_out_data", int'(a_out_data), 0);
        chk("midreset_out_last", int'(a_out_last), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_max_ramp();
        frame_a(1'b0, 1'b0, 1'b1, 0);
        drain_a("postreset_drain");

        frame_b(1'b0);
        frame_b(1'b1);
        drain_b("k4_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
